// File: rtl/mmio_pkg.sv
// mmio_pkg: shared MMIO offset map and status-word bit positions.
// Imported by the MMIO responder and by the core's load/store decode so both
// agree on the register layout. No ports; constants and one helper only.
package mmio_pkg;

  // Register offsets within the MMIO region (addr[7:0])
  localparam logic [7:0] STATUS = 8'h00;
  localparam logic [7:0] RX     = 8'h04;
  localparam logic [7:0] TX     = 8'h08;
  localparam logic [7:0] CYC    = 8'h10;
  localparam logic [7:0] INST   = 8'h14;
  localparam logic [7:0] CLR    = 8'h18;

  // Status word bit positions
  localparam int ST_TX_EMPTY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVF      = 2;

  // Build the status word from its three flags; all other bits read 0.
  function automatic logic [31:0] status_word(input logic ovf,
                                              input logic rx_valid,
                                              input logic tx_empty);
    logic [31:0] w;
    w              = '0;
    w[ST_OVF]      = ovf;
    w[ST_RX_VALID] = rx_valid;
    w[ST_TX_EMPTY] = tx_empty;
    return w;
  endfunction

endpackage

// File: rtl/mmio_counters.sv
// mmio_counters: free-running cycle counter and retired-instruction counter.
// Ports: clk/rst (sync, active-high), clr_i forces both to 0 on the next edge
// (beats a same-cycle increment), inst_i counts retirements, cyc_o/inst_o are the counts.
module mmio_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inst_i,
  output logic [CNT_W-1:0] cyc_o,
  output logic [CNT_W-1:0] inst_o
);

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;

  // Both counters wrap naturally modulo 2^CNT_W.
  always_comb begin
    cyc_d  = cyc_q + CNT_W'(1);
    inst_d = inst_i ? inst_q + CNT_W'(1) : inst_q;
    if (clr_i) begin
      cyc_d  = '0;
      inst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
    end
  end

  assign cyc_o  = cyc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: decodes the MMIO region of the data-memory path, returns
// registered load data one cycle after re, and owns the UART TX/RX handshakes.
// Ports: clk/rst (sync, active-high); addr/wdata/wmask/re from execute; rdata/hit
// to mem/wb; inst_retired; rx_data/rx_valid/rx_ready and tx_data/tx_valid/tx_ready to the UART.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter logic [3:0] REGION = 4'h8,
  parameter int         CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        inst_retired,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic       sel;
  logic [7:0] off;
  logic       rd_req, stat_rd, rx_rd;
  logic       tx_wr, clr_wr;
  logic       tx_hs, tx_take, tx_drop;

  logic [31:0] rdata_q, rdata_d;
  logic        hit_q, hit_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rd_mux;

  logic [CNT_W-1:0] cyc_cnt, inst_cnt;

  // Only the region nibble and the low offset byte are decoded.
  logic unused_bits;
  assign unused_bits = ^{addr[27:8], wdata[31:8]};

  assign sel     = (addr[31:28] == REGION);
  assign off     = addr[7:0];
  assign rd_req  = re & sel;
  assign stat_rd = rd_req & (off == STATUS);
  assign rx_rd   = rd_req & (off == RX);
  assign tx_wr   = sel & (off == TX) & wmask[0];
  assign clr_wr  = sel & (off == CLR) & (|wmask);

  // A write lands if the buffer is empty or is draining this very cycle;
  // otherwise it is dropped and flagged as an overflow.
  assign tx_hs   = tx_valid_q & tx_ready;
  assign tx_take = tx_wr & (~tx_valid_q | tx_hs);
  assign tx_drop = tx_wr & tx_valid_q & ~tx_hs;

  // Pop is combinational so the UART advances in the same cycle we sample.
  assign rx_ready = ~rst & rx_rd & rx_valid;

  mmio_counters #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_wr),
    .inst_i (inst_retired),
    .cyc_o  (cyc_cnt),
    .inst_o (inst_cnt)
  );

  // Read mux uses current (pre-write, pre-clear) state.
  always_comb begin
    rd_mux = '0;
    case (off)
      STATUS:  rd_mux = status_word(ovf_q, rx_valid, ~tx_valid_q);
      RX:      rd_mux = rx_valid ? {24'b0, rx_data} : 32'b0;
      CYC:     rd_mux = 32'(cyc_cnt);
      INST:    rd_mux = 32'(inst_cnt);
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = sel ? rd_mux : 32'b0;
    hit_d = rd_req;

    tx_valid_d = tx_valid_q;
    if (tx_take)    tx_valid_d = 1'b1;
    else if (tx_hs) tx_valid_d = 1'b0;
    tx_data_d = tx_take ? wdata[7:0] : tx_data_q;

    // Set wins over the read-to-clear.
    ovf_d = tx_drop | (ovf_q & ~stat_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rdata    = rdata_q;
  assign hit      = hit_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: scenario tasks drive the MMIO responder; expected load
// results are queued when a read is issued and compared when rdata appears.
// A small counter model tracks expected cycle/instruction counts.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  wmask;
  logic        re;
  logic [31:0] rdata;
  logic        hit;
  logic        inst_retired;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  mmio_responder dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .wdata        (wdata),
    .wmask        (wmask),
    .re           (re),
    .rdata        (rdata),
    .hit          (hit),
    .inst_retired (inst_retired),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  int errs   = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    logic        hit;
    logic [31:0] rd;
  } exp_t;
  exp_t sbq[$];

  // Reference counters, reset/cleared/incremented from the bench's own stimulus.
  logic [31:0] cyc_m, inst_m;
  always @(posedge clk) begin
    if (rst || (addr[31:28] == 4'h8 && addr[7:0] == 8'h18 && wmask != 4'h0)) begin
      cyc_m  <= 32'h0;
      inst_m <= 32'h0;
    end else begin
      cyc_m  <= cyc_m + 32'h1;
      if (inst_retired) inst_m <= inst_m + 32'h1;
    end
  end

  logic [31:0] boot_addr [3];
  logic [31:0] boot_data [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    re    = 1'b0;
    wmask = 4'h0;
    wdata = 32'h0;
    addr  = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a);
    addr  = a;
    re    = 1'b1;
    wmask = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr  = a;
    wdata = d;
    wmask = m;
    re    = 1'b0;
  endtask

  task automatic sb_push(input string nm, input logic h, input logic [31:0] d);
    exp_t t;
    t.nm  = nm;
    t.hit = h;
    t.rd  = d;
    sbq.push_back(t);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; idle(); inst_retired = 1'b0; tx_ready = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h99;
    rd(32'h8000_0004);
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin errs++; $display("FAIL rst_rx_ready: got %b want 0", rx_ready); end
    tick(); tick();
    checks++;
    if (rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    checks++;
    if (hit !== 1'b0) begin errs++; $display("FAIL rst_hit: got %b want 0", hit); end
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h0)
      begin errs++; $display("FAIL rst_tx: got valid=%b data=%h want 0/00", tx_valid, tx_data); end
    rst = 1'b0; rx_valid = 1'b0; idle();
    for (int i = 0; i < 3; i++) begin
      rd(boot_addr[i]);
      sb_push($sformatf("boot_rd%0d", i), 1'b1, boot_data[i]);
      tick();
      e = sbq.pop_front(); checks++;
      if (rdata !== e.rd || hit !== e.hit) begin
        errs++;
        $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit);
      end
    end
    idle();
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    wr(32'h8000_0008, 32'hABCD_EF41, 4'h1);
    tick(); idle();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41)
      begin errs++; $display("FAIL tx_load: got valid=%b data=%h want 1/41", tx_valid, tx_data); end
    repeat (5) tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41)
      begin errs++; $display("FAIL tx_hold: got valid=%b data=%h want 1/41", tx_valid, tx_data); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errs++; $display("FAIL tx_drain: got valid=%b want 0", tx_valid); end
  endtask

  task automatic test_tx_ovf();
    exp_t e;
    tx_ready = 1'b0;
    wr(32'h8000_0008, 32'h41, 4'h1); tick();
    wr(32'h8000_0008, 32'h42, 4'h1); tick();
    idle();
    checks++;
    if (tx_data !== 8'h41 || tx_valid !== 1'b1)
      begin errs++; $display("FAIL ovf_keep: got valid=%b data=%h want 1/41", tx_valid, tx_data); end
    // First status read shows ovf, second sees it cleared.
    for (int i = 0; i < 2; i++) begin
      rd(32'h8000_0000);
      sb_push($sformatf("ovf_status%0d", i), 1'b1, (i == 0) ? 32'h4 : 32'h0);
      tick();
      e = sbq.pop_front(); checks++;
      if (rdata !== e.rd || hit !== e.hit) begin
        errs++;
        $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit);
      end
    end
    // Write in the handshake cycle is accepted and keeps tx_valid high.
    tx_ready = 1'b1;
    wr(32'h8000_0008, 32'h43, 4'h1); tick();
    tx_ready = 1'b0; idle();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h43)
      begin errs++; $display("FAIL tx_hs_write: got valid=%b data=%h want 1/43", tx_valid, tx_data); end
    // Read and write to TX in the same cycle: write is dropped (ovf), read gives 0.
    addr = 32'h8000_0008; wdata = 32'h45; wmask = 4'h1; re = 1'b1;
    sb_push("rw_same_cycle", 1'b1, 32'h0);
    tick(); idle();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    checks++;
    if (tx_data !== 8'h43) begin errs++; $display("FAIL ovf_drop2: got data=%h want 43", tx_data); end
    rd(32'h8000_0000); sb_push("ovf_status_again", 1'b1, 32'h4); tick(); idle();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin errs++; $display("FAIL ovf_drain: got valid=%b want 0", tx_valid); end
  endtask

  task automatic test_rx();
    exp_t e;
    rx_valid = 1'b1; rx_data = 8'h5A;
    rd(32'h8000_0004);
    sb_push("rx_read", 1'b1, 32'h5A);
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin errs++; $display("FAIL rx_pop: got %b want 1", rx_ready); end
    @(posedge clk); #1;
    idle();
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin errs++; $display("FAIL rx_pop_len: got %b want 0", rx_ready); end
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    rx_valid = 1'b0;
    rd(32'h8000_0004);
    sb_push("rx_empty", 1'b1, 32'h0);
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin errs++; $display("FAIL rx_nopop: got %b want 0", rx_ready); end
    @(posedge clk); #1;
    idle();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
  endtask

  task automatic test_counters();
    exp_t e;
    idle();
    for (int i = 0; i < 100; i++) begin
      inst_retired = i[0];
      tick();
    end
    inst_retired = 1'b0;
    rd(32'h8000_0014); sb_push("inst_count", 1'b1, inst_m); tick();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    rd(32'h8000_0010); sb_push("cyc_preclear", 1'b1, cyc_m); tick();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    // Clear overrides a same-cycle retirement.
    inst_retired = 1'b1;
    wr(32'h8000_0018, 32'h0, 4'hF); tick();
    inst_retired = 1'b0;
    rd(32'h8000_0014); sb_push("inst_postclear", 1'b1, 32'h0); tick();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit || rdata > 32'h1)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    rd(32'h8000_0010); sb_push("cyc_postclear", 1'b1, cyc_m); tick();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit || rdata > 32'h2)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    idle();
  endtask

  task automatic test_misc();
    exp_t e;
    rd(32'h8000_001C); sb_push("unmapped", 1'b1, 32'h0); tick();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    rx_valid = 1'b1; rx_data = 8'h77;
    rd(32'h8000_0004); sb_push("rx_77", 1'b1, 32'h77); tick();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    rx_valid = 1'b0; idle(); tick();
    checks++;
    if (rdata !== 32'h77 || hit !== 1'b0)
      begin errs++; $display("FAIL hold_no_re: got rdata=%h hit=%b want 00000077/0", rdata, hit); end
    rd(32'h1000_0010); tick(); idle();
    checks++;
    if (hit !== 1'b0) begin errs++; $display("FAIL off_region: got hit=%b want 0", hit); end
  endtask

  task automatic test_wrap();
    exp_t e;
    force dut.u_cnt.cyc_q = 32'hFFFF_FFFF;
    rd(32'h8000_0010); sb_push("cyc_max", 1'b1, 32'hFFFF_FFFF);
    #1;
    release dut.u_cnt.cyc_q;
    @(posedge clk); #1;
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    rd(32'h8000_0010); sb_push("cyc_wrap", 1'b1, 32'h0); tick();
    e = sbq.pop_front(); checks++;
    if (rdata !== e.rd || hit !== e.hit)
      begin errs++; $display("FAIL %s: got rdata=%h hit=%b want rdata=%h hit=%b", e.nm, rdata, hit, e.rd, e.hit); end
    idle();
  endtask

  task automatic test_reset_mid_tx();
    tx_ready = 1'b0;
    wr(32'h8000_0008, 32'h55, 4'h1); tick(); idle();
    checks++;
    if (tx_valid !== 1'b1) begin errs++; $display("FAIL midtx_load: got valid=%b want 1", tx_valid); end
    rst = 1'b1; rx_valid = 1'b1; rd(32'h8000_0004);
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin errs++; $display("FAIL midtx_rx_ready: got %b want 0", rx_ready); end
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h0)
      begin errs++; $display("FAIL midtx_reset: got valid=%b data=%h want 0/00", tx_valid, tx_data); end
    rst = 1'b0; rx_valid = 1'b0; idle(); tick();
  endtask

  initial begin
    boot_addr[0] = 32'h8000_0010; boot_data[0] = 32'h0;
    boot_addr[1] = 32'h8000_0014; boot_data[1] = 32'h0;
    boot_addr[2] = 32'h8000_0000; boot_data[2] = 32'h1;
    test_reset();
    test_tx();
    test_tx_ovf();
    test_rx();
    test_counters();
    test_misc();
    test_wrap();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Responder side of the core's data-memory access path, covering memory-mapped I/O only.
- The core's execute stage issues load/store requests: address, write data, byte mask, read/write enable. This block decodes the MMIO region and returns registered read data in the core's mem/wb stage.
- Owns the UART TX/RX ready-valid handshakes, the cycle counter and the retired-instruction counter.
- Sits beside the data memory; the core's load-select mux chooses between the two by address.

Parameters:
- REGION, default 4'h8, value of addr[31:28] that selects MMIO.
- CNT_W, default 32, width of both performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst synchronous, active-high; clock clk
- addr  in  32  byte address from the execute stage ALU
- wdata  in  32  store data, already lane-aligned
- wmask  in  4  byte-lane write enables; 0 means no write
- re  in  1  load request this cycle
- rdata  out  32  load data, valid the cycle after re
- hit  out  1  registered; the previous cycle's request decoded to MMIO
- inst_retired  in  1  one non-bubble instruction committed this cycle
- rx_data  in  8  UART receive byte
- rx_valid  in  1  UART has a byte
- rx_ready  out  1  pop pulse to the UART
- tx_data  out  8  byte to transmit
- tx_valid  out  1  TX byte pending
- tx_ready  in  1  UART accepts the byte

Behaviour:
- Select: sel = (addr[31:28] == REGION). Offset = addr[7:0].
- Read map (data sampled in the re cycle, presented on rdata the next cycle):
  - 0x00 status: {29'b0, ovf, rx_valid, ~tx_valid}.
  - 0x04 RX: {24'b0, rx_data}.
  - 0x10 cycle counter.
  - 0x14 instruction counter.
  - Any other offset returns 0.
- Write map:
  - 0x08 TX: requires wmask[0]=1.
  - 0x18 counter clear: any nonzero wmask.
  - Other offsets are ignored.
- Read latency: exactly 1 cycle. rdata and hit are registered. Without re, rdata holds its previous value and hit=0.
- RX pop:
  - When re, sel, offset 0x04 and rx_valid are all true in the same cycle, rx_ready=1 combinationally for that cycle only.
  - Read with rx_valid=0 returns 0 and issues no pop.
- TX, one-entry buffer:
  - A write to 0x08 while tx_valid=0 latches wdata[7:0] into tx_data. tx_valid goes high next cycle.
  - tx_valid stays high until the cycle where tx_valid and tx_ready are both 1; it clears on the following edge.
  - Write while tx_valid=1 is dropped and sets sticky ovf.
  - Write in the same cycle the pending byte handshakes is accepted: the new byte loads and tx_valid stays 1.
- ovf:
  - Cleared by a status (0x00) read; rdata still shows ovf=1 for that read.
  - If a set and a clear occur in the same cycle, set wins.
- Counters:
  - Cycle counter increments every non-reset cycle.
  - Instruction counter increments when inst_retired=1.
  - Both wrap modulo 2^CNT_W.
  - A clear write forces both to 0 on the next edge, overriding the same-cycle increment.
  - A read in the same cycle as a clear returns the pre-clear value.
- Simultaneous re and nonzero wmask: the write takes effect; the read returns pre-write state.
- Reset state:
  - rdata=0, hit=0, tx_valid=0, tx_data=0, ovf=0, both counters=0.
  - rx_ready=0 while rst=1.
  - Reset mid-transmit drops the pending byte without a handshake.
- No state machine beyond the TX pending bit; all register updates happen on rising clk.

Decomposition:
- mmio_pkg holds the offset constants (STATUS=8'h00, RX=8'h04, TX=8'h08, CYC=8'h10, INST=8'h14, CLR=8'h18) and the status bit positions. The core's load/store decode imports the same package.
- Sub-module mmio_counters contains both CNT_W counters with clear and increment inputs. Decode, TX buffer and read mux stay in the top module.

Test Plan:
- Reset, then read 0x80000000 with rx_valid=0 and tx_ready=1 -> next cycle rdata=32'h1, hit=1. Counters read 0 right after reset.
- Write 0x80000008, wdata=32'h41, wmask=4'h1, with tx_ready=0 for 5 cycles -> tx_valid=1 and tx_data=8'h41 held. Raise tx_ready -> tx_valid=0 the next cycle.
- While tx_valid=1, write 0x42 -> tx_data stays 8'h41; status read returns 32'h4; a second status read returns bit2=0.
- rx_valid=1, rx_data=8'h5A, read 0x80000004 -> rx_ready high for exactly that cycle; rdata=32'h5A next cycle. Repeat with rx_valid=0 -> rdata=0, no rx_ready pulse.
- Run 100 cycles with inst_retired on alternate cycles, then write 0x80000018 while reading 0x80000010 -> rdata equals the pre-clear count; the next read of 0x14 returns a value at most 1.
- Preload the cycle counter to 32'hFFFFFFFF via force -> one cycle later it reads 0. Read 0x8000001C -> 0. Read 0x10000010 -> hit=0.
